// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: redirect input, instruction-memory request port and decode-side instruction port.
// Handshakes: mem_req/mem_addr hold until mem_ack; an instruction transfers when ins_valid & ins_ready.
interface instr_fetch_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          ins_valid;
  logic [DW-1:0] ins_data;
  logic [AW-1:0] ins_pc;
  logic          ins_ready;

  modport master (
    input  redirect_valid, redirect_pc, mem_ack, mem_rdata, ins_ready,
    output mem_req, mem_addr, ins_valid, ins_data, ins_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_ack, mem_rdata, ins_ready,
    input  mem_req, mem_addr, ins_valid, ins_data, ins_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding sequential memory reads into a small prefetch FIFO,
// with redirect flushing the FIFO and dropping any response that is still in flight.
module instr_fetch #(
  parameter int            AW       = 8,
  parameter int            DW       = 16,
  parameter int            DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus,
  output logic [1:0]    state_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DISCARD = 2'd2} state_t;

  state_t        state_q;
  logic [AW-1:0] fetch_pc_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_req_q;
  logic [DW-1:0] data_q [DEPTH];
  logic [AW-1:0] pc_q   [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  logic          head_valid;
  logic          redirect;
  logic          push;
  logic          pop;
  logic [CW-1:0] occ_d;
  logic          has_space;
  logic [AW-1:0] next_seq;

  assign head_valid = (count_q != '0);
  assign redirect   = bus.redirect_valid;
  // Redirect wins over both ends of the FIFO: the returning word and any pop are ignored.
  assign push       = (state_q == REQ) && bus.mem_ack && !redirect;
  assign pop        = head_valid && bus.ins_ready && !redirect;
  assign occ_d      = count_q + CW'(push) - CW'(pop);
  assign has_space  = (occ_d < CW'(DEPTH));
  assign next_seq   = mem_addr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          data_q[wr_ptr_q] <= bus.mem_rdata;
          pc_q[wr_ptr_q]   <= mem_addr_q;
          wr_ptr_q         <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= occ_d;
      end

      case (state_q)
        IDLE: begin
          if (redirect) begin
            fetch_pc_q <= bus.redirect_pc;
            mem_addr_q <= bus.redirect_pc;
            mem_req_q  <= 1'b1;
            state_q    <= REQ;
          end else if (has_space) begin
            mem_addr_q <= fetch_pc_q;
            mem_req_q  <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (redirect) begin
            fetch_pc_q <= bus.redirect_pc;
            // Without an ack the request cannot be withdrawn, so its response must be dropped later.
            if (bus.mem_ack) mem_addr_q <= bus.redirect_pc;
            else             state_q    <= DISCARD;
          end else if (bus.mem_ack) begin
            fetch_pc_q <= next_seq;
            if (has_space) begin
              mem_addr_q <= next_seq;
            end else begin
              mem_req_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (redirect) fetch_pc_q <= bus.redirect_pc;
          if (bus.mem_ack) begin
            mem_addr_q <= redirect ? bus.redirect_pc : fetch_pc_q;
            state_q    <= REQ;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.ins_valid = head_valid;
  assign bus.ins_data  = data_q[rd_ptr_q];
  assign bus.ins_pc    = pc_q[rd_ptr_q];
  assign state_o       = state_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, backpressure, slow memory, redirects, wrap, reset.
module tb_instr_fetch;
  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state;
  int         checks   = 0;
  int         failures = 0;

  instr_fetch_if #(.AW(AW), .DW(DW)) bus ();

  instr_fetch #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_PC(8'h00)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state)
  );

  always #5 clk = ~clk;

  // Memory model: each address returns a word derived from the address itself.
  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  always_comb bus.mem_rdata = word_of(bus.mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic req, input logic [AW-1:0] addr);
    chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'(req));
    chk({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(addr));
  endtask

  task automatic chk_ins(input string tag, input logic valid, input logic [AW-1:0] pc);
    chk({tag, ".ins_valid"}, 32'(bus.ins_valid), 32'(valid));
    if (valid) begin
      chk({tag, ".ins_pc"}, 32'(bus.ins_pc), 32'(pc));
      chk({tag, ".ins_data"}, 32'(bus.ins_data), 32'(word_of(pc)));
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.mem_ack        = 1'b0;
    bus.ins_ready      = 1'b0;
    step();
    step();
    chk_fetch("reset", 1'b0, 8'h00);
    chk_ins("reset", 1'b0, 8'h00);
    chk("reset.ins_data", 32'(bus.ins_data), 32'h0);
    chk("reset.ins_pc", 32'(bus.ins_pc), 32'h0);
    chk("reset.state", 32'(state), 32'd0);

    // Streaming: zero-wait memory and decode always ready.
    reset         = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.ins_ready = 1'b1;
    step();
    chk_fetch("first_req", 1'b1, 8'h00);
    chk_ins("first_req", 1'b0, 8'h00);
    chk("first_req.state", 32'(state), 32'd1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk_fetch("stream", 1'b1, AW'(k + 1));
      chk_ins("stream", 1'b1, AW'(k));
    end

    // Backpressure from a fresh reset: only DEPTH entries are accepted.
    reset         = 1'b1;
    bus.mem_ack   = 1'b0;
    bus.ins_ready = 1'b0;
    step();
    chk_fetch("bp_reset", 1'b0, 8'h00);
    reset       = 1'b0;
    bus.mem_ack = 1'b1;
    step();
    chk_fetch("bp_c1", 1'b1, 8'h00);
    chk_ins("bp_c1", 1'b0, 8'h00);
    step();
    chk_fetch("bp_c2", 1'b1, 8'h01);
    chk_ins("bp_c2", 1'b1, 8'h00);
    step();
    chk_fetch("bp_c3", 1'b0, 8'h01);
    chk_ins("bp_c3", 1'b1, 8'h00);
    chk("bp_c3.state", 32'(state), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_fetch("bp_hold", 1'b0, 8'h01);
      chk_ins("bp_hold", 1'b1, 8'h00);
    end
    bus.ins_ready = 1'b1;
    step();
    chk_fetch("bp_rel1", 1'b1, 8'h02);
    chk_ins("bp_rel1", 1'b1, 8'h01);
    step();
    chk_fetch("bp_rel2", 1'b1, 8'h03);
    chk_ins("bp_rel2", 1'b1, 8'h02);

    // Slow memory: request held stable for three waiting cycles.
    bus.mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_fetch("wait_hold", 1'b1, 8'h03);
      chk_ins("wait_hold", 1'b0, 8'h00);
    end
    bus.mem_ack = 1'b1;
    step();
    chk_fetch("wait_ack", 1'b1, 8'h04);
    chk_ins("wait_ack", 1'b1, 8'h03);

    // Redirect to 0x40 while the request for 0x05 is outstanding.
    step();
    chk_fetch("pre_redir", 1'b1, 8'h05);
    chk_ins("pre_redir", 1'b1, 8'h04);
    bus.mem_ack = 1'b0;
    step();
    chk_fetch("pend05", 1'b1, 8'h05);
    chk_ins("pend05", 1'b0, 8'h00);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h40;
    step();
    chk_fetch("discard1", 1'b1, 8'h05);
    chk_ins("discard1", 1'b0, 8'h00);
    chk("discard1.state", 32'(state), 32'd2);
    bus.redirect_valid = 1'b0;
    step();
    chk_fetch("discard2", 1'b1, 8'h05);
    chk_ins("discard2", 1'b0, 8'h00);
    bus.mem_ack = 1'b1;
    step();
    chk_fetch("after_drop", 1'b1, 8'h40);
    chk_ins("after_drop", 1'b0, 8'h00);
    chk("after_drop.state", 32'(state), 32'd1);
    bus.mem_ack = 1'b0;
    step();
    chk_fetch("wait40", 1'b1, 8'h40);
    chk_ins("wait40", 1'b0, 8'h00);
    bus.mem_ack = 1'b1;
    step();
    chk_fetch("got40", 1'b1, 8'h41);
    chk_ins("got40", 1'b1, 8'h40);

    // Redirect to 0xFE coinciding with an ack: that word is dropped, then the address wraps.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'hFE;
    step();
    chk_fetch("redir_fe", 1'b1, 8'hFE);
    chk_ins("redir_fe", 1'b0, 8'h00);
    bus.redirect_valid = 1'b0;
    step();
    chk_fetch("wrap1", 1'b1, 8'hFF);
    chk_ins("wrap1", 1'b1, 8'hFE);
    step();
    chk_fetch("wrap2", 1'b1, 8'h00);
    chk_ins("wrap2", 1'b1, 8'hFF);
    step();
    chk_fetch("wrap3", 1'b1, 8'h01);
    chk_ins("wrap3", 1'b1, 8'h00);
    step();
    chk_fetch("wrap4", 1'b1, 8'h02);
    chk_ins("wrap4", 1'b1, 8'h01);

    // Reset mid-request with a buffered entry; the stale ack must be ignored.
    bus.mem_ack   = 1'b0;
    bus.ins_ready = 1'b0;
    step();
    chk_fetch("pre_rst", 1'b1, 8'h02);
    chk_ins("pre_rst", 1'b1, 8'h01);
    reset       = 1'b1;
    bus.mem_ack = 1'b1;
    step();
    chk_fetch("mid_rst", 1'b0, 8'h00);
    chk_ins("mid_rst", 1'b0, 8'h00);
    chk("mid_rst.ins_data", 32'(bus.ins_data), 32'h0);
    chk("mid_rst.ins_pc", 32'(bus.ins_pc), 32'h0);
    chk("mid_rst.state", 32'(state), 32'd0);
    reset         = 1'b0;
    bus.ins_ready = 1'b1;
    step();
    chk_fetch("refetch1", 1'b1, 8'h00);
    chk_ins("refetch1", 1'b0, 8'h00);
    step();
    chk_fetch("refetch2", 1'b1, 8'h01);
    chk_ins("refetch2", 1'b1, 8'h00);

    // Fill the buffer to reach IDLE, then redirect from IDLE; the pop in that cycle is ignored.
    bus.ins_ready = 1'b0;
    step();
    chk_fetch("full_idle", 1'b0, 8'h01);
    chk_ins("full_idle", 1'b1, 8'h00);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h80;
    bus.ins_ready      = 1'b1;
    step();
    chk_fetch("idle_redir", 1'b1, 8'h80);
    chk_ins("idle_redir", 1'b0, 8'h00);
    bus.redirect_valid = 1'b0;
    step();
    chk_fetch("idle_redir2", 1'b1, 8'h81);
    chk_ins("idle_redir2", 1'b1, 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit that sits between the program counter and the decode stage. It generates sequential fetch addresses and issues single-outstanding read requests to instruction memory. Returned words go into a small prefetch buffer, and are handed to decode over a valid/ready handshake together with their address. A redirect (branch/jump) reloads the fetch address and flushes everything in flight.

## Interface
- AW, 8, fetch address width
- DW, 16, instruction word width
- DEPTH, 2, prefetch buffer entries (power of two, ≥2)
- RESET_PC, 0, first fetch address after reset
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- redirect_valid  in  1  load redirect_pc as the new fetch address; flush the buffer
- redirect_pc  in  AW  redirect target
- mem_req  out  1  read request to instruction memory (registered)
- mem_addr  out  AW  request address (registered)
- mem_ack  in  1  memory accepts the request and returns data this cycle
- mem_rdata  in  DW  read data, valid when mem_ack=1
- ins_valid  out  1  buffer head holds an instruction
- ins_data  out  DW  instruction at the buffer head
- ins_pc  out  AW  address of ins_data
- ins_ready  in  1  decode accepts the head this cycle

## Operation
- States:
  - IDLE: no request outstanding.
  - REQ: mem_req=1, awaiting mem_ack.
  - DISCARD: a request is outstanding whose response must be dropped.
- Reset: state IDLE, fetch_pc=RESET_PC, buffer empty.
  - Output reset values: mem_req=0, mem_addr=0, ins_valid=0, ins_data=0, ins_pc=0.
- Space rule: occ_next = occ + push − pop. A new request is issued only if occ_next + (request still pending next cycle) < DEPTH.
- IDLE→REQ when the space rule holds: mem_req←1, mem_addr←fetch_pc.
- REQ, mem_ack=1:
  - Push {mem_rdata, mem_addr}.
  - fetch_pc←mem_addr+1, wrapping modulo 2^AW (0xFF+1 = 0x00).
  - If the space rule holds, stay in REQ with mem_addr←mem_addr+1 (back-to-back). Otherwise go to IDLE with mem_req←0.
- Request stability: once mem_req=1, mem_req and mem_addr hold until mem_ack. A request is never withdrawn.
- Pop: when ins_valid & ins_ready, the head is removed and the next entry appears the following cycle.
- Simultaneous push and pop on a full buffer are both legal; occupancy is unchanged.
- Redirect (highest priority):
  - Buffer flushed (ins_valid←0 next cycle). A pop in the same cycle is ignored.
  - fetch_pc←redirect_pc.
  - If the state is REQ without mem_ack this cycle, go to DISCARD. In DISCARD, hold the request until mem_ack, drop that data, then go to REQ with mem_addr←fetch_pc.
  - If mem_ack=1 in the redirect cycle, that data is dropped and the next request targets redirect_pc.
  - Otherwise go to REQ with mem_addr←redirect_pc next cycle.
  - A redirect during DISCARD updates fetch_pc only; it is last-wins.
- Reset during any state, including mid-request, returns all state to reset values next cycle. Any in-flight memory response is ignored.

## Timing
- First mem_req: asserted the first cycle after reset deasserts, with mem_addr=RESET_PC.
- mem_ack in cycle N: ins_valid=1 and ins_data/ins_pc updated in cycle N+1, provided the buffer was empty or flushed.
- Throughput: with zero-wait mem_ack and ins_ready held high, one instruction per cycle sustained.
- Redirect in cycle N with no pending request: mem_req/mem_addr=redirect_pc in N+1. The first redirected instruction is visible in N+2 at the earliest.
- ins_* outputs are registered; no combinational path from mem_ack or ins_ready to any output.

## Test plan
- Reset, then mem_ack tied high and ins_ready high → mem_addr sequence 0,1,2,3…; ins_pc matches in lockstep, lagging by 1 cycle; one instruction per cycle.
- ins_ready=0 for 6 cycles with mem_ack high → exactly DEPTH=2 entries accepted, then mem_req=0. Release ins_ready → pcs 0,1,2 delivered in order, none lost or duplicated.
- mem_ack delayed 3 cycles → mem_req and mem_addr stable for all 3 waiting cycles; data appears on ins_data the cycle after ack.
- Redirect to 0x40 while a request for 0x05 is pending, ack 2 cycles later → data for 0x05 never appears on ins_*. Next mem_addr=0x40; buffer empty until 0x40 returns.
- Redirect to 0xFE, all ready → mem_addr 0xFE, 0xFF, 0x00, 0x01 (wrap).
- Reset asserted while mem_req=1 and the buffer holds 2 entries → next cycle all outputs 0. Refetch starts at RESET_PC; stale ack data dropped.
